// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, opcodes and the fetch FSM state type.
package cpu_pkg;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned DATA_W = 24;
    localparam int unsigned OPC_W  = 8;

    localparam logic [OPC_W-1:0] HALT_OP = 8'hFF;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 8'h00,
        OP_HALT = HALT_OP
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: reset to RESET_PC, load on redirect, otherwise increment with wrap.
module pc_reg #(
    parameter int unsigned       ADDR_W   = 24,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_q, pc_d;

    // Load beats increment; the add wraps naturally at 2^ADDR_W.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_pc;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: reads IRAM at pc, waits MEM_LAT cycles, then holds the
// word in IR until decode takes it; handles start, halt-opcode and branch redirects.
module fetch_controller
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
    parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       MEM_LAT  = 1,
    parameter int unsigned       OPC_W    = cpu_pkg::OPC_W,
    parameter logic [OPC_W-1:0]  HALT_OP  = cpu_pkg::HALT_OP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              iram_read,
    output logic [ADDR_W-1:0] iram_addr,
    input  logic [DATA_W-1:0] iram_data,
    output logic [DATA_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
    output logic              busy,
    output fetch_state_t      state_dbg
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    fetch_state_t      state_q, state_d;
    logic [2:0]        lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic              ir_valid_q, ir_valid_d;
    logic              iram_read_q, iram_read_d;
    logic              halted_q, halted_d;
    logic              busy_q, busy_d;
    logic              pc_load, pc_inc;
    logic [ADDR_W-1:0] pc;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (pc_load),
        .load_pc (redirect_pc),
        .inc     (pc_inc),
        .pc      (pc)
    );

    // Handshake: ir_out/ir_valid are held stable while ir_valid=1 and ir_ready=0; a word
    // is consumed on any rising edge where both are high. A redirect in FETCH or HOLD
    // drops ir_valid and restarts fetch at redirect_pc, even in the same cycle as a take.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FETCH;
                    lat_cnt_d = '0;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_load    = 1'b1;
                    lat_cnt_d  = '0;
                    ir_valid_d = 1'b0;
                end else if (lat_cnt_q == LAT_LAST) begin
                    ir_d       = iram_data;
                    ir_valid_d = 1'b1;
                    pc_inc     = 1'b1;
                    lat_cnt_d  = '0;
                    state_d    = HOLD;
                end else begin
                    lat_cnt_d = lat_cnt_q + 3'd1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_load    = 1'b1;
                    lat_cnt_d  = '0;
                    ir_valid_d = 1'b0;
                    state_d    = FETCH;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    lat_cnt_d  = '0;
                    state_d    = (ir_q[DATA_W-1 -: OPC_W] == HALT_OP) ? HALT : FETCH;
                end
            end
            HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    lat_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        iram_read_d = (state_d == FETCH);
        halted_d    = (state_d == HALT);
        busy_d      = (state_d == FETCH) || (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            iram_read_q <= 1'b0;
            halted_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            iram_read_q <= iram_read_d;
            halted_q    <= halted_d;
            busy_q      <= busy_d;
        end
    end

    assign iram_read = iram_read_q;
    assign iram_addr = pc;
    assign pc_out    = pc;
    assign ir_out    = ir_q;
    assign ir_valid  = ir_valid_q;
    assign halted    = halted_q;
    assign busy      = busy_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: cycle table at MEM_LAT=1, hand sequence and random
// traffic against a transaction-level model at MEM_LAT=3.
module tb_fetch_controller;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: MEM_LAT=1
    logic         rst_a = 1'b1, start_a = 1'b0, rdy_a = 1'b0, redir_a = 1'b0;
    logic [23:0]  rpc_a = '0;
    logic         read_a, valid_a, halted_a, busy_a;
    logic [23:0]  addr_a, data_a, ir_a, pc_a;
    fetch_state_t st_a;

    // Instance B: MEM_LAT=3
    logic         rst_b = 1'b1, start_b = 1'b0, rdy_b = 1'b0, redir_b = 1'b0;
    logic [23:0]  rpc_b = '0;
    logic         read_b, valid_b, halted_b, busy_b;
    logic [23:0]  addr_b, data_b, ir_b, pc_b;
    fetch_state_t st_b;

    fetch_controller #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .iram_read(read_a), .iram_addr(addr_a),
        .iram_data(data_a), .ir_out(ir_a), .ir_valid(valid_a), .ir_ready(rdy_a),
        .redirect(redir_a), .redirect_pc(rpc_a), .pc_out(pc_a), .halted(halted_a),
        .busy(busy_a), .state_dbg(st_a)
    );

    fetch_controller #(.MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .iram_read(read_b), .iram_addr(addr_b),
        .iram_data(data_b), .ir_out(ir_b), .ir_valid(valid_b), .ir_ready(rdy_b),
        .redirect(redir_b), .redirect_pc(rpc_b), .pc_out(pc_b), .halted(halted_b),
        .busy(busy_b), .state_dbg(st_b)
    );

    function automatic logic [23:0] word_at(input logic [23:0] a);
        case (a)
            24'h000000: return 24'd100;
            24'h000001: return 24'd10;
            24'h000002: return 24'd50;
            24'h000003: return 24'hFF0000;
            24'h000020: return 24'h123456;
            24'hFFFFFF: return 24'h00ABCD;
            default:    return {a[7:0] ^ 8'h3C, a[15:0] ^ 16'h9E37};
        endcase
    endfunction

    // Latency memory: the word only appears once read has been held at one address
    // for the full latency; any other cycle returns junk.
    logic [23:0] junk;
    logic [3:0]  cnt_a, cnt_b;
    always @(posedge clk) begin
        junk <= 24'($urandom);
        if (rst_a || !read_a || (redir_a && busy_a)) cnt_a <= '0;
        else cnt_a <= cnt_a + 4'd1;
        if (rst_b || !read_b || (redir_b && busy_b)) cnt_b <= '0;
        else cnt_b <= cnt_b + 4'd1;
    end
    assign data_a = (read_a && cnt_a == 4'd0) ? word_at(addr_a) : junk;
    assign data_b = (read_b && cnt_b == 4'd2) ? word_at(addr_b) : junk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, start, rdy, redir;
        logic [23:0] rpc;
        logic        read;
        logic [23:0] addr;
        logic        valid;
        logic [23:0] ir;
        logic        halted, busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, start, rdy, redir, input logic [23:0] rpc,
                       input logic read, input logic [23:0] addr, input logic valid,
                       input logic [23:0] ir, input logic halted, busy);
        vec_t v;
        v.rst = rst; v.start = start; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.read = read; v.addr = addr; v.valid = valid; v.ir = ir;
        v.halted = halted; v.busy = busy;
        tbl.push_back(v);
    endtask

    // Transaction model state for instance B
    int          m_mode;  // 0 idle, 1 running, 2 halted
    logic [23:0] m_addr;  // address of the word currently being fetched or held
    logic [23:0] w, held_ir, exp_pc;
    logic        s, r, d, acc, hold_chk;
    logic [23:0] rp;
    int          stall;
    int          reads;

    initial begin
        // ---------------- Table phase, instance A ----------------
        add(1,0,0,0,24'h0,        0,24'h0,0,24'd0,0,0);
        add(0,0,1,0,24'h0,        0,24'h0,0,24'd0,0,0);
        add(0,1,1,0,24'h0,        1,24'h0,0,24'd0,0,1);
        add(0,0,1,0,24'h0,        0,24'h1,1,24'd100,0,1);
        add(0,0,1,0,24'h0,        1,24'h1,0,24'd100,0,1);
        add(0,0,1,0,24'h0,        0,24'h2,1,24'd10,0,1);
        for (int k = 0; k < 5; k++)
            add(0,0,0,0,24'h0,    0,24'h2,1,24'd10,0,1);
        add(0,0,1,0,24'h0,        1,24'h2,0,24'd10,0,1);
        add(0,0,1,0,24'h0,        0,24'h3,1,24'd50,0,1);
        add(0,0,0,1,24'h20,       1,24'h20,0,24'd50,0,1);
        add(0,0,0,0,24'h0,        0,24'h21,1,word_at(24'h20),0,1);
        add(0,0,1,1,24'h3,        1,24'h3,0,word_at(24'h20),0,1);
        add(0,0,0,0,24'h0,        0,24'h4,1,word_at(24'h3),0,1);
        add(0,0,1,0,24'h0,        0,24'h4,0,word_at(24'h3),1,0);
        add(0,0,1,1,24'h20,       0,24'h4,0,word_at(24'h3),1,0);
        add(0,1,0,0,24'h0,        1,24'h4,0,word_at(24'h3),0,1);
        add(0,0,1,0,24'h0,        0,24'h5,1,word_at(24'h4),0,1);
        add(0,0,1,1,24'hFFFFFF,   1,24'hFFFFFF,0,word_at(24'h4),0,1);
        add(0,0,1,0,24'h0,        0,24'h0,1,word_at(24'hFFFFFF),0,1);
        add(0,0,1,0,24'h0,        1,24'h0,0,word_at(24'hFFFFFF),0,1);
        add(0,0,0,0,24'h0,        0,24'h1,1,24'd100,0,1);
        add(0,0,0,1,24'h3,        1,24'h3,0,24'd100,0,1);
        add(0,0,0,0,24'h0,        0,24'h4,1,word_at(24'h3),0,1);
        add(0,0,1,1,24'h20,       1,24'h20,0,word_at(24'h3),0,1);
        add(1,0,1,0,24'h0,        0,24'h0,0,24'd0,0,0);
        add(0,0,0,1,24'h55,       0,24'h0,0,24'd0,0,0);

        foreach (tbl[i]) begin
            rst_a = tbl[i].rst; start_a = tbl[i].start; rdy_a = tbl[i].rdy;
            redir_a = tbl[i].redir; rpc_a = tbl[i].rpc;
            @(posedge clk); #1;
            chk($sformatf("tbl_ctl row=%0d", i),
                64'({read_a, valid_a, halted_a, busy_a, addr_a, pc_a}),
                64'({tbl[i].read, tbl[i].valid, tbl[i].halted, tbl[i].busy,
                     tbl[i].addr, tbl[i].addr}));
            chk($sformatf("tbl_ir row=%0d", i), 64'(ir_a), 64'(tbl[i].ir));
        end
        rst_a = 1'b1;

        // ---------------- Hand sequence, instance B (MEM_LAT=3) ----------------
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("b_reset", 64'({read_b, valid_b, halted_b, busy_b, addr_b, ir_b, st_b}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE}));
        rst_b = 1'b0; rdy_b = 1'b1; start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        reads = read_b ? 1 : 0;
        for (int i = 0; i < 10 && !valid_b; i++) begin
            @(posedge clk); #1;
            if (read_b) reads++;
        end
        chk("b_lat_reads", 64'(reads), 64'd3);
        chk("b_first_word", 64'({valid_b, ir_b, pc_b}), 64'({1'b1, 24'd100, 24'h1}));
        @(posedge clk); #1;
        chk("b_refetch", 64'({read_b, valid_b, addr_b}), 64'({1'b1, 1'b0, 24'h1}));
        @(posedge clk); #1;
        chk("b_second_fetch_cycle", 64'({read_b, st_b}), 64'({1'b1, FETCH}));
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("b_mid_fetch_reset",
            64'({read_b, valid_b, halted_b, busy_b, addr_b, ir_b, st_b}),
            64'({1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 24'h0, IDLE}));
        rst_b = 1'b0; rdy_b = 1'b0;

        // ---------------- Random traffic, instance B ----------------
        m_mode = 0; m_addr = 24'h0; stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 15) == 0);
            rp = ($urandom_range(0, 3) == 0) ? 24'hFFFFFF - 24'($urandom_range(0, 2))
                                             : 24'($urandom_range(0, 511));
            start_b = s; rdy_b = r; redir_b = d; rpc_b = rp;

            acc = (m_mode == 1) && valid_b && r;
            hold_chk = (m_mode == 1) && valid_b && !r && !d;
            held_ir = ir_b;
            w = word_at(m_addr);
            if (acc) begin
                chk($sformatf("rand_word addr=%h", m_addr), 64'(ir_b), 64'(w));
                m_addr = m_addr + 24'd1;
            end
            if (m_mode == 1) begin
                if (d) begin
                    m_addr = rp;
                    stall = 0;
                end else if (acc && w[23:16] == 8'hFF) begin
                    m_mode = 2;
                end
            end else if (s) begin
                m_mode = 1;
            end

            @(posedge clk); #1;
            chk("rand_mode", 64'({halted_b, busy_b}), 64'({m_mode == 2, m_mode == 1}));
            exp_pc = (m_mode == 1 && valid_b) ? m_addr + 24'd1 : m_addr;
            chk("rand_pc", 64'(pc_b), 64'(exp_pc));
            chk("rand_read_excl", 64'({read_b & valid_b, read_b & ~busy_b}), 64'd0);
            if (hold_chk)
                chk("rand_hold", 64'({valid_b, ir_b}), 64'({1'b1, held_ir}));
            if (m_mode == 1 && !valid_b) stall++;
            else stall = 0;
            if (stall > 3)
                chk("rand_liveness", 64'(stall), 64'd3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
